// File: rtl/itcm_loader.sv
// Byte-stream loader for the instruction TCM: parses LOAD/GO frames, writes LE words
// into the itcm and releases the CPU from reset with the entry PC from a valid GO.
module itcm_loader #(
  parameter int          ADDR_WIDTH       = 14,
  parameter logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000,
  parameter logic [7:0]  MAGIC_LOAD       = 8'hA5,
  parameter logic [7:0]  MAGIC_GO         = 8'h5A
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic [31:0]           reset_pc,
  output logic                  frame_done,
  output logic                  err_csum,
  output logic                  err_range
);

  typedef enum logic [2:0] {
    IDLE, L_ADDR, L_CNT, L_DATA, L_CSUM, G_PC, G_CSUM, RUN
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  hi_bad_q, hi_bad_d;
  logic                  wrapped_q, wrapped_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            sum_q, sum_d;
  logic [31:0]           pc_stage_q, pc_stage_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic [31:0]           reset_pc_q, reset_pc_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_csum_q, err_csum_d;
  logic                  err_range_q, err_range_d;

  logic accept;

  assign rx_ready   = 1'b1;
  assign accept     = rx_valid & rx_ready;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign reset_pc   = reset_pc_q;
  assign frame_done = frame_done_q;
  assign err_csum   = err_csum_q;
  assign err_range  = err_range_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    ptr_d        = ptr_q;
    hi_bad_d     = hi_bad_q;
    wrapped_d    = wrapped_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    sum_d        = sum_q;
    pc_stage_d   = pc_stage_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    reset_pc_d   = reset_pc_q;
    frame_done_d = 1'b0;
    err_csum_d   = err_csum_q;
    err_range_d  = err_range_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          idx_d = 2'd0;
          sum_d = 8'd0;
          if (rx_data == MAGIC_LOAD)    state_d = L_ADDR;
          else if (rx_data == MAGIC_GO) state_d = G_PC;
        end
        L_ADDR: begin
          sum_d  = sum_q + rx_data;
          addr_d = {rx_data, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Low two bits select a byte inside the word and are ignored.
            ptr_d     = addr_d[ADDR_WIDTH+1:2];
            hi_bad_d  = |addr_d[31:ADDR_WIDTH+2];
            wrapped_d = 1'b0;
            state_d   = L_CNT;
          end
        end
        L_CNT: begin
          sum_d        = sum_q + rx_data;
          words_left_d = {rx_data, words_left_q[15:8]};
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            state_d = (words_left_d == 16'd0) ? L_CSUM : L_DATA;
          end else begin
            idx_d = 2'd1;
          end
        end
        L_DATA: begin
          sum_d  = sum_q + rx_data;
          word_d = {rx_data, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (!hi_bad_q && !wrapped_q) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = ptr_q;
              imem_wdata_d = word_d;
            end else begin
              err_range_d = 1'b1;
            end
            // Once the pointer steps past the top word every later word is out of range.
            if (&ptr_q) wrapped_d = 1'b1;
            ptr_d        = ptr_q + 1'b1;
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) state_d = L_CSUM;
          end
        end
        L_CSUM: begin
          if (rx_data != sum_q) err_csum_d = 1'b1;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
        G_PC: begin
          sum_d      = sum_q + rx_data;
          pc_stage_d = {rx_data, pc_stage_q[31:8]};
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = G_CSUM;
        end
        G_CSUM: begin
          frame_done_d = 1'b1;
          if (rx_data == sum_q) begin
            reset_pc_d  = pc_stage_q;
            cpu_reset_d = 1'b0;
            state_d     = RUN;
          end else begin
            err_csum_d = 1'b1;
            state_d    = IDLE;
          end
        end
        RUN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
      hi_bad_q     <= 1'b0;
      wrapped_q    <= 1'b0;
      words_left_q <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      pc_stage_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      reset_pc_q   <= RESET_PC_DEFAULT;
      frame_done_q <= 1'b0;
      err_csum_q   <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
      hi_bad_q     <= hi_bad_d;
      wrapped_q    <= wrapped_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      sum_q        <= sum_d;
      pc_stage_q   <= pc_stage_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      reset_pc_q   <= reset_pc_d;
      frame_done_q <= frame_done_d;
      err_csum_q   <= err_csum_d;
      err_range_q  <= err_range_d;
    end
  end

endmodule

// File: tb/tb_itcm_loader.sv
// Directed table-driven bench for itcm_loader: one row per clock, outputs checked 1ns after the edge.
module tb_itcm_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic [31:0]   reset_pc;
  logic          frame_done;
  logic          err_csum;
  logic          err_range;

  itcm_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .reset_pc(reset_pc),
    .frame_done(frame_done), .err_csum(err_csum), .err_range(err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          v;
    logic [7:0]    d;
    logic          we;
    logic [AW-1:0] a;
    logic [31:0]   w;
    logic          cr;
    logic [31:0]   pc;
    logic          fd;
    logic          ec;
    logic          er;
  } vec_t;

  vec_t        tbl[$];
  logic        cur_cr;
  logic [31:0] cur_pc;
  logic        cur_ec, cur_er;
  int          checks   = 0;
  int          failures = 0;

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic we, input logic [AW-1:0] a, input logic [31:0] w,
                     input logic fd);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.we = we; r.a = a; r.w = w;
    r.cr = cur_cr; r.pc = cur_pc; r.fd = fd; r.ec = cur_ec; r.er = cur_er;
    tbl.push_back(r);
  endtask

  task automatic rs();
    cur_cr = 1'b1; cur_pc = 32'h0; cur_ec = 1'b0; cur_er = 1'b0;
    add(1'b1, 1'b0, 8'h00, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic by(input logic [7:0] d);
    add(1'b0, 1'b1, d, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    add(1'b0, 1'b0, 8'hA5, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic fdb(input logic [7:0] d);
    add(1'b0, 1'b1, d, 1'b0, '0, 32'h0, 1'b1);
  endtask

  task automatic by4(input logic [31:0] x);
    for (int i = 0; i < 4; i++) by(x[8*i +: 8]);
  endtask

  // Data word: three plain bytes, then the 4th either writes (ok) or raises err_range.
  task automatic word(input logic [31:0] x, input logic [AW-1:0] a, input logic ok);
    for (int i = 0; i < 3; i++) by(x[8*i +: 8]);
    if (!ok) cur_er = 1'b1;
    add(1'b0, 1'b1, x[31:24], ok, a, x, 1'b0);
  endtask

  task automatic step(input int idx, input vec_t r);
    reset = r.rst; rx_valid = r.v; rx_data = r.d;
    @(posedge clk); #1;
    checks++;
    if (imem_we !== r.we || cpu_reset !== r.cr || reset_pc !== r.pc ||
        frame_done !== r.fd || err_csum !== r.ec || err_range !== r.er ||
        rx_ready !== 1'b1 || (r.we && (imem_addr !== r.a || imem_wdata !== r.w))) begin
      failures++;
      $display("FAIL row%0d: got we=%b a=%h w=%h cr=%b pc=%h fd=%b ec=%b er=%b rdy=%b; want we=%b a=%h w=%h cr=%b pc=%h fd=%b ec=%b er=%b",
               idx, imem_we, imem_addr, imem_wdata, cpu_reset, reset_pc, frame_done,
               err_csum, err_range, rx_ready, r.we, r.a, r.w, r.cr, r.pc, r.fd, r.ec, r.er);
    end
  endtask

  logic [7:0]    s1 [16] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h13,
                             8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h84};
  logic [AW-1:0] wa [4];
  logic [31:0]   wd [4];
  int            nwr, nfd;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    // reset state
    rs();
    // LOAD two words at 0, with idle gaps that must not be taken as bytes
    by(8'hA5); by4(32'h0); by(8'h02); idle(); by(8'h00);
    word(32'h0000_0013, 14'd0, 1'b1); idle();
    word(32'h0000_006F, 14'd1, 1'b1); fdb(8'h84); by(8'h00);
    // GO to 0x100, then bytes in RUN are dropped
    by(8'h5A); by4(32'h0000_0100);
    cur_cr = 1'b0; cur_pc = 32'h0000_0100; fdb(8'h01);
    by(8'hA5); by(8'h00); by(8'h02); by(8'h5A); by(8'h00);
    rs();
    // bad checksum still writes; a later valid GO releases the CPU
    by(8'hA5); by4(32'h0000_0010); by(8'h01); by(8'h00);
    word(32'hDEAD_BEEF, 14'd4, 1'b1);
    cur_ec = 1'b1; fdb(8'h00);
    by(8'h5A); by4(32'h0000_0100);
    cur_cr = 1'b0; cur_pc = 32'h0000_0100; fdb(8'h01);
    rs();
    // address above the itcm: no write, err_range
    by(8'hA5); by4(32'h0001_0000); by(8'h01); by(8'h00);
    word(32'h4433_2211, 14'd0, 1'b0); fdb(8'hAC);
    rs();
    // pointer wraps past the top word on the second word
    by(8'hA5); by4(32'h0000_FFFC); by(8'h02); by(8'h00);
    word(32'h0403_0201, 14'h3FFF, 1'b1);
    word(32'h0807_0605, 14'd0, 1'b0); fdb(8'h21);
    rs();
    // CNT=0 goes straight to checksum
    by(8'hA5); by4(32'h0); by(8'h00); by(8'h00); fdb(8'h00);
    // garbage, failed GO, then a good GO
    by(8'h00); by(8'hFF); by(8'h33);
    by(8'h5A); by4(32'h8000_0000);
    cur_ec = 1'b1; fdb(8'h00);
    by(8'h5A); by4(32'h8000_0000);
    cur_cr = 1'b0; cur_pc = 32'h8000_0000; fdb(8'h80);

    for (int i = 0; i < tbl.size(); i++) begin
      step(i, tbl[i]);
      if (i == 0) begin
        checks++;
        if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
          failures++;
          $display("FAIL reset_bus: got a=%h w=%h want 0/0", imem_addr, imem_wdata);
        end
      end
    end

    // reset after the 3rd data byte of a LOAD
    reset = 1'b1; rx_valid = 1'b0; @(posedge clk); #1;
    reset = 1'b0;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1; rx_data = s1[i]; @(posedge clk); #1;
      if (imem_we) nwr++;
    end
    reset = 1'b1; rx_valid = 1'b0; @(posedge clk); #1;
    checks++;
    if (nwr != 0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
        cpu_reset !== 1'b1 || reset_pc !== 32'h0 || frame_done !== 1'b0 ||
        err_csum !== 1'b0 || err_range !== 1'b0) begin
      failures++;
      $display("FAIL midreset: got nwr=%0d we=%b a=%h w=%h cr=%b pc=%h fd=%b ec=%b er=%b want all reset values",
               nwr, imem_we, imem_addr, imem_wdata, cpu_reset, reset_pc, frame_done, err_csum, err_range);
    end

    // fresh back-to-back LOAD afterwards
    reset = 1'b0; nwr = 0; nfd = 0;
    for (int i = 0; i < 18; i++) begin
      rx_valid = (i < 16); rx_data = (i < 16) ? s1[i] : 8'h00;
      @(posedge clk); #1;
      if (imem_we) begin
        if (nwr < 4) begin wa[nwr] = imem_addr; wd[nwr] = imem_wdata; end
        nwr++;
      end
      if (frame_done) nfd++;
    end
    rx_valid = 1'b0;
    checks++;
    if (nwr != 2) begin
      failures++;
      $display("FAIL reload_nwr: got %0d want 2", nwr);
    end else begin
      checks++;
      if (wa[0] !== 14'd0 || wd[0] !== 32'h13 || wa[1] !== 14'd1 || wd[1] !== 32'h6F) begin
        failures++;
        $display("FAIL reload_data: got %h:%h %h:%h want 0000:00000013 0001:0000006f",
                 wa[0], wd[0], wa[1], wd[1]);
      end
    end
    checks++;
    if (nfd != 1 || err_csum !== 1'b0 || err_range !== 1'b0 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL reload_status: got fd=%0d ec=%b er=%b cr=%b want 1/0/0/1",
               nfd, err_csum, err_range, cpu_reset);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
